// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage initiator for an external combinational ALU.
// S1 holds the decoded instruction and drives the ALU. S2 registers the ALU
// result, flags-derived branch outcome and writeback controls for downstream.
module alu_issue_ctrl #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream instruction handshake
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [XLEN-1:0]       in_rs1_val,
    input  logic [XLEN-1:0]       in_rs2_val,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    // ALU interface
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [2:0]            alu_op,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_sf,
    input  logic                  alu_zf,
    // downstream writeback handshake
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    output logic                  out_is_branch,
    output logic                  out_branch_taken,
    output logic                  out_illegal
);

    // Instruction classes handled by this unit
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU opcode map
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_MUL  = 3'd5;
    localparam logic [2:0] ALU_MULH = 3'd6;
    localparam logic [2:0] ALU_NONE = 3'd7;

    // Branch funct3 encodings
    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_free;
    logic s1_advance;
    logic accept;

    assign s2_free    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready   = !s1_valid || s2_free;
    assign accept     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Decode of the incoming fields
    // ------------------------------------------------------------------
    logic            arith_ok;
    logic [2:0]      arith_op;
    logic            dec_legal;
    logic            dec_use_imm;
    logic            dec_branch;
    logic [2:0]      dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;

    // funct3 to ALU op for the shared add/xor/or/and group
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        arith_ok = 1'b1;
        arith_op = ALU_NONE;
        case (in_funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b100:  arith_op = ALU_XOR;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_ok = 1'b0;
        endcase
    end

    // Classify the instruction and pick the ALU operation
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_branch  = 1'b0;
        dec_op      = ALU_NONE;
        case (in_opcode)
            OPC_OP: begin
                if (in_funct7 == F7_BASE) begin
                    dec_legal = arith_ok;
                    dec_op    = arith_op;
                end else if (in_funct7 == F7_ALT && in_funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end else if (in_funct7 == F7_MULDIV && in_funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_MUL;
                end else if (in_funct7 == F7_MULDIV && in_funct3 == 3'b001) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_MULH;
                end
            end
            OPC_OP_IMM: begin
                // funct7 carries immediate bits here and is ignored
                dec_legal   = arith_ok;
                dec_op      = arith_op;
                dec_use_imm = 1'b1;
            end
            OPC_BRANCH: begin
                case (in_funct3)
                    BR_EQ, BR_NE, BR_LT, BR_GE: begin
                        dec_legal  = 1'b1;
                        dec_branch = 1'b1;
                        dec_op     = ALU_SUB;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec_op = ALU_NONE;
        end
    end

    assign dec_a = dec_legal ? in_rs1_val : '0;
    assign dec_b = !dec_legal ? '0 : (dec_use_imm ? in_imm : in_rs2_val);

    // ------------------------------------------------------------------
    // S1: issue register driving the ALU
    // ------------------------------------------------------------------
    logic [2:0]            s1_op;
    logic [XLEN-1:0]       s1_a;
    logic [XLEN-1:0]       s1_b;
    logic [REG_ADDR_W-1:0] s1_rd;
    logic [2:0]            s1_funct3;
    logic                  s1_branch;
    logic                  s1_illegal;

    // S1 valid follows accept/advance; payload loads only on accept
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: only the valid bit is reset; the payload is don't-care while invalid and is masked at the ALU port.
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_op      <= dec_op;
            s1_a       <= dec_a;
            s1_b       <= dec_b;
            s1_rd      <= in_rd;
            s1_funct3  <= in_funct3;
            s1_branch  <= dec_branch;
            s1_illegal <= !dec_legal;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    assign alu_op = s1_valid ? s1_op : ALU_NONE;
    assign alu_a  = s1_valid ? s1_a  : '0;
    assign alu_b  = s1_valid ? s1_b  : '0;

    // ------------------------------------------------------------------
    // Branch resolution from the ALU subtract result and flags
    // ------------------------------------------------------------------
    logic br_ovf;
    logic br_lt;
    logic br_taken;

    // Signed less-than is SF xor overflow of rs1 - rs2
    always_comb begin
        br_ovf   = (s1_a[XLEN-1] != s1_b[XLEN-1]) && (alu_result[XLEN-1] != s1_a[XLEN-1]);
        br_lt    = alu_sf ^ br_ovf;
        br_taken = 1'b0;
        case (s1_funct3)
            BR_EQ:   br_taken = alu_zf;
            BR_NE:   br_taken = !alu_zf;
            BR_LT:   br_taken = br_lt;
            BR_GE:   br_taken = !br_lt;
            default: br_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // S2: registered writeback record
    // ------------------------------------------------------------------
    // Capture on advance, drop valid when consumed, hold everything on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_rd           <= '0;
            out_we           <= 1'b0;
            out_is_branch    <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (s1_advance) begin
            out_valid        <= 1'b1;
            out_result       <= s1_illegal ? '0 : alu_result;
            out_rd           <= s1_rd;
            out_we           <= !s1_illegal && !s1_branch && (s1_rd != '0);
            out_is_branch    <= s1_branch;
            out_branch_taken <= s1_branch && br_taken;
            out_illegal      <= s1_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed stimulus for alu_issue_ctrl, with a
// bench-side ALU and a transaction-level model (queue of expected records).
module tb_alu_issue_ctrl;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_sf;
    logic        alu_zf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_is_branch;
    logic        out_branch_taken;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_funct7       (in_funct7),
        .in_rs1_val      (in_rs1_val),
        .in_rs2_val      (in_rs2_val),
        .in_imm          (in_imm),
        .in_rd           (in_rd),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_op          (alu_op),
        .alu_result      (alu_result),
        .alu_sf          (alu_sf),
        .alu_zf          (alu_zf),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_rd          (out_rd),
        .out_we          (out_we),
        .out_is_branch   (out_is_branch),
        .out_branch_taken(out_branch_taken),
        .out_illegal     (out_illegal)
    );

    // Combinational ALU the unit drives
    logic [63:0] alu_prod;
    assign alu_prod = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            3'd5:    alu_result = alu_prod[31:0];
            3'd6:    alu_result = alu_prod[63:32];
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_sf = alu_result[31];
    assign alu_zf = (alu_result == 32'h0);

    // ------------------------------------------------------------------
    // Reference model: what each accepted instruction must produce
    // ------------------------------------------------------------------
    typedef struct {
        int          acc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        taken;
        logic        ill;
    } rec_t;

    function automatic rec_t predict(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [4:0] rd);
        rec_t        r;
        logic [31:0] y;
        logic [63:0] p;
        longint      ps;
        bit          ok;
        logic [2:0]  op;
        logic [31:0] res;
        r.acc = 0; r.op = 3'd7; r.a = 0; r.b = 0; r.result = 0; r.rd = rd;
        r.we = 0; r.br = 0; r.taken = 0; r.ill = 1;
        ok = 0; op = 3'd7; res = 0;
        y = (opc == OP_I) ? imm : rs2;
        ps = longint'($signed(rs1)) * longint'($signed(rs2));
        p = ps;
        if (opc == OP_I || (opc == OP_R && f7 == 7'h00)) begin
            ok = 1;
            case (f3)
                3'b000:  begin op = 3'd0; res = rs1 + y; end
                3'b100:  begin op = 3'd4; res = rs1 ^ y; end
                3'b110:  begin op = 3'd3; res = rs1 | y; end
                3'b111:  begin op = 3'd2; res = rs1 & y; end
                default: ok = 0;
            endcase
        end else if (opc == OP_R && f7 == 7'h20 && f3 == 3'b000) begin
            ok = 1; op = 3'd1; res = rs1 - rs2;
        end else if (opc == OP_R && f7 == 7'h01 && f3 == 3'b000) begin
            ok = 1; op = 3'd5; res = rs1 * rs2;
        end else if (opc == OP_R && f7 == 7'h01 && f3 == 3'b001) begin
            ok = 1; op = 3'd6; res = p[63:32];
        end
        if (ok) begin
            r.ill = 0; r.op = op; r.a = rs1; r.b = y; r.result = res; r.we = (rd != 0);
        end else if (opc == OP_B && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101)) begin
            r.ill = 0; r.op = 3'd1; r.a = rs1; r.b = rs2; r.result = rs1 - rs2; r.br = 1;
            case (f3)
                3'b000:  r.taken = (rs1 == rs2);
                3'b001:  r.taken = (rs1 != rs2);
                3'b100:  r.taken = ($signed(rs1) < $signed(rs2));
                default: r.taken = !($signed(rs1) < $signed(rs2));
            endcase
        end
        return r;
    endfunction

    rec_t q[$];
    int   edge_cnt = 0;
    bit   started  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge: retire on output handshake, enqueue on accept
    initial begin : model
        rec_t r;
        bit   vis;
        bit   ir;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                started = 1;
            end else if (started) begin
                vis = (q.size() > 0) && (q[0].acc + 1 < edge_cnt);
                ir  = !(q.size() == 2 && !out_ready);
                if (vis && out_ready) void'(q.pop_front());
                if (in_valid && ir) begin
                    r = predict(in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val, in_imm, in_rd);
                    r.acc = edge_cnt;
                    q.push_back(r);
                end
            end
            edge_cnt++;
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin : compare
        bit   vis;
        bit   has_s1;
        rec_t s1;
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                vis    = (q.size() > 0) && (q[0].acc + 1 < edge_cnt);
                has_s1 = 0;
                if (q.size() == 2) begin
                    has_s1 = 1; s1 = q[1];
                end else if (q.size() == 1 && !vis) begin
                    has_s1 = 1; s1 = q[0];
                end
                check("out_valid", 32'(out_valid), 32'(vis));
                check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
                if (vis) begin
                    check("out_result", out_result, q[0].result);
                    check("out_rd", 32'(out_rd), 32'(q[0].rd));
                    check("out_we", 32'(out_we), 32'(q[0].we));
                    check("out_is_branch", 32'(out_is_branch), 32'(q[0].br));
                    check("out_branch_taken", 32'(out_branch_taken), 32'(q[0].taken));
                    check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
                end
                if (has_s1) begin
                    check("alu_op", 32'(alu_op), 32'(s1.op));
                    check("alu_a", alu_a, s1.a);
                    check("alu_b", alu_b, s1.b);
                end else begin
                    check("alu_op_idle", 32'(alu_op), 32'd7);
                    check("alu_a_idle", alu_a, 32'h0);
                    check("alu_b_idle", alu_b, 32'h0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_opcode  = opc;
        in_funct3  = f3;
        in_funct7  = f7;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_imm     = imm;
        in_rd      = rd;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_instr();
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: opc = OP_R;
            4, 5, 6:    opc = OP_I;
            7, 8:       opc = OP_B;
            default:    opc = 7'($urandom_range(0, 127));
        endcase
        case ($urandom_range(0, 4))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            3:       f7 = 7'h01;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        rs1 = pick_val();
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : pick_val();
        set_instr(opc, 3'($urandom_range(0, 7)), f7, rs1, rs2, pick_val(),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : driver
        rec_t r;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_instr(7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 5'h0);
        in_valid = 1'b0;
        repeat (3) step();

        // reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", out_result, 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'd7);
        rst = 1'b0;

        // hand-computed values pinning the model
        r = predict(OP_R, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 5'd3);
        check("model_add", r.result, 32'd12);
        check("model_add_we", 32'(r.we), 32'd1);
        r = predict(OP_B, 3'b100, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 5'd0);
        check("model_blt_res", r.result, 32'h7FFF_FFFF);
        check("model_blt_taken", 32'(r.taken), 32'd1);
        r = predict(OP_B, 3'b101, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 5'd0);
        check("model_bge_taken", 32'(r.taken), 32'd0);
        r = predict(OP_R, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd4);
        check("model_mulh", r.result, 32'hFFFF_FFFF);
        r = predict(OP_I, 3'b000, 7'h55, 32'd10, 32'd0, 32'hFFFF_FFFD, 5'd1);
        check("model_addi", r.result, 32'd7);
        r = predict(7'b0110111, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 5'd1);
        check("model_lui_ill", 32'(r.ill), 32'd1);
        r = predict(OP_R, 3'b100, 7'h01, 32'd1, 32'd2, 32'd3, 5'd1);
        check("model_f7_1_f3_4_ill", 32'(r.ill), 32'd1);

        // add, two edges to the output
        set_instr(OP_R, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 5'd3);
        step(); in_valid = 1'b0;
        step();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", out_result, 32'd12);
        check("add_we", 32'(out_we), 32'd1);
        check("add_rd", 32'(out_rd), 32'd3);

        // blt / bge with signed overflow
        set_instr(OP_B, 3'b100, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 5'd0);
        step(); in_valid = 1'b0;
        step();
        check("blt_taken", 32'(out_branch_taken), 32'd1);
        check("blt_result", out_result, 32'h7FFF_FFFF);
        check("blt_we", 32'(out_we), 32'd0);
        set_instr(OP_B, 3'b101, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 5'd0);
        step(); in_valid = 1'b0;
        step();
        check("bge_taken", 32'(out_branch_taken), 32'd0);
        check("bge_is_branch", 32'(out_is_branch), 32'd1);

        // back-to-back addi, xor, mulh
        set_instr(OP_I, 3'b000, 7'h00, 32'd10, 32'd0, 32'hFFFF_FFFD, 5'd1);
        step();
        set_instr(OP_R, 3'b100, 7'h00, 32'hF0F0_1234, 32'h0FF0_4321, 32'd0, 5'd2);
        step();
        check("b2b_addi", out_result, 32'd7);
        set_instr(OP_R, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd3);
        step();
        check("b2b_xor", out_result, 32'hFF00_5115);
        in_valid = 1'b0;
        step();
        check("b2b_mulh", out_result, 32'hFFFF_FFFF);
        step();

        // backpressure: 3 offered, 2 held
        out_ready = 1'b0;
        set_instr(OP_R, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 5'd1);
        step();
        set_instr(OP_R, 3'b000, 7'h20, 32'd10, 32'd4, 32'd0, 5'd2);
        step();
        set_instr(OP_R, 3'b110, 7'h00, 32'h0F00, 32'h00F0, 32'd0, 5'd3);
        step();
        in_valid = 1'b0;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", out_result, 32'd3);
        step();
        check("bp_hold", out_result, 32'd3);
        out_ready = 1'b1;
        repeat (4) step();

        // illegal encodings
        set_instr(7'b0110111, 3'b000, 7'h00, 32'd9, 32'd9, 32'd9, 5'd5);
        step(); in_valid = 1'b0;
        step();
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_we", 32'(out_we), 32'd0);
        check("ill_result", out_result, 32'h0);
        set_instr(OP_R, 3'b100, 7'h01, 32'd9, 32'd9, 32'd9, 5'd5);
        step(); in_valid = 1'b0;
        step();
        check("ill_m_flag", 32'(out_illegal), 32'd1);

        // reset with S1 and S2 both occupied
        out_ready = 1'b0;
        set_instr(OP_R, 3'b000, 7'h00, 32'd100, 32'd1, 32'd0, 5'd7);
        step();
        set_instr(OP_R, 3'b000, 7'h00, 32'd200, 32'd1, 32'd0, 5'd8);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", out_result, 32'h0);
        check("mid_rst_rd", 32'(out_rd), 32'd0);
        check("mid_rst_we", 32'(out_we), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op), 32'd7);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // randomized traffic with backpressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 7) rand_instr();
            else in_valid = 1'b0;
            step();
        end

        // drain
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
